// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: shared definitions for the ALU sequencer.
//   - ALU op codes (the ALU S input)
//   - FSM state encodings
//   - instruction word layout (packed struct + field positions)
package alu_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_SHL = 3'b100,
    OP_SHR = 3'b101,
    OP_XOR = 3'b110,
    OP_NOT = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  // Instruction field bit positions.
  localparam int OP_HI   = 15;
  localparam int OP_LO   = 13;
  localparam int IMM_BIT = 12;
  localparam int RD_HI   = 11;
  localparam int RD_LO   = 10;
  localparam int RA_HI   = 9;
  localparam int RA_LO   = 8;
  localparam int LOW_HI  = 7;
  localparam int LOW_LO  = 0;

  // Packed view of the 16-bit instruction, MSB first.
  typedef struct packed {
    logic [2:0] op;
    logic       imm;
    logic [1:0] rd;
    logic [1:0] ra;
    logic [7:0] low;   // imm8 when imm=1, else [1:0] = rb
  } instr_t;

  function automatic logic [1:0] rb_of(input instr_t i);
    return i.low[1:0];
  endfunction

endpackage

// File: rtl/alu_sequencer_regfile4x8.sv
// regfile4x8: small register file for the ALU sequencer.
//   clk, rst         : clock, synchronous active-high clear
//   we/waddr/wdata   : synchronous write port
//   ra_*/rb_*/dbg_*  : three combinational read ports
module regfile4x8 #(
  parameter int NREGS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata,
  input  logic [1:0] ra_addr,
  output logic [7:0] ra_data,
  input  logic [1:0] rb_addr,
  output logic [7:0] rb_data,
  input  logic [1:0] dbg_addr,
  output logic [7:0] dbg_data
);

  logic [NREGS-1:0][7:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) mem_q <= '0;
    else     mem_q <= mem_d;
  end

  assign ra_data  = mem_q[ra_addr];
  assign rb_data  = mem_q[rb_addr];
  assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: single-issue control stage in front of the 8-bit
// combinational ALU. IDLE -> EXEC -> WB, one instruction per 3 cycles.
//   clk, rst                 : clock, synchronous active-high reset
//   instr_valid/ready/instr  : instruction handshake (no skid buffer)
//   alu_a/alu_b/alu_s        : ALU operands/op (held outside EXEC)
//   alu_d/alu_c              : ALU result/carry
//   result_valid/result/rd   : writeback pulse and data
//   flag_c/flag_z            : carry/zero flags
//   dbg_sel/dbg_data         : combinational register peek
// Build option: define ALU_SEQ_FLAGS_EN to get real flag registers;
// otherwise flag_c/flag_z are tied to 0 and alu_c is ignored.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int NREGS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_s,
  input  logic [7:0]  alu_d,
  input  logic        alu_c,
  output logic        result_valid,
  output logic [7:0]  result,
  output logic [1:0]  result_rd,
  output logic        flag_c,
  output logic        flag_z,
  input  logic [1:0]  dbg_sel,
  output logic [7:0]  dbg_data
);

  state_e     state_q, state_d;
  instr_t     instr_q, instr_d;
  logic [7:0] res_q, res_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic [2:0] s_q, s_d;
  logic [7:0] rf_a, rf_b, exec_b;
  logic       wb_en;

  regfile4x8 #(.NREGS(NREGS)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .we       (wb_en),
    .waddr    (instr_q.rd),
    .wdata    (res_q),
    .ra_addr  (instr_q.ra),
    .ra_data  (rf_a),
    .rb_addr  (rb_of(instr_q)),
    .rb_data  (rf_b),
    .dbg_addr (dbg_sel),
    .dbg_data (dbg_data)
  );

  assign exec_b = instr_q.imm ? instr_q.low : rf_b;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    res_d   = res_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    wb_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          instr_d = instr_t'(instr);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Remember the operands so the ALU inputs stay still afterwards.
        a_d     = rf_a;
        b_d     = exec_b;
        s_d     = instr_q.op;
        res_d   = alu_d;
        state_d = ST_WB;
      end
      ST_WB: begin
        wb_en   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      res_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      res_q   <= res_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
    end
  end

  // Live operands during EXEC; held copies everywhere else.
  assign alu_a = (state_q == ST_EXEC) ? rf_a       : a_q;
  assign alu_b = (state_q == ST_EXEC) ? exec_b     : b_q;
  assign alu_s = (state_q == ST_EXEC) ? instr_q.op : s_q;

  assign instr_ready  = (state_q == ST_IDLE);
  assign result_valid = (state_q == ST_WB);
  assign result       = res_q;
  assign result_rd    = instr_q.rd;

`ifdef ALU_SEQ_FLAGS_EN
  logic res_c_q, res_c_d;
  logic flag_c_q, flag_c_d, flag_z_q, flag_z_d;

  always_comb begin
    res_c_d  = res_c_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    if (state_q == ST_EXEC) res_c_d = alu_c;
    if (wb_en) begin
      flag_c_d = res_c_q;
      flag_z_d = (res_q == 8'h00);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_c_q  <= 1'b0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      res_c_q  <= res_c_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
    end
  end

  assign flag_c = flag_c_q;
  assign flag_z = flag_z_q;
`else
  logic unused_alu_c;
  assign unused_alu_c = alu_c;
  assign flag_c = 1'b0;
  assign flag_z = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed, table-driven bench for alu_sequencer with a
// behavioural ALU attached to the alu_* ports.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [7:0]  alu_a, alu_b, alu_d;
  logic [2:0]  alu_s;
  logic        alu_c;
  logic        result_valid;
  logic [7:0]  result;
  logic [1:0]  result_rd;
  logic        flag_c, flag_z;
  logic [1:0]  dbg_sel;
  logic [7:0]  dbg_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.NREGS(4)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_d(alu_d), .alu_c(alu_c),
    .result_valid(result_valid), .result(result), .result_rd(result_rd),
    .flag_c(flag_c), .flag_z(flag_z),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  // Behavioural ALU.
  always_comb begin
    alu_d = 8'h00;
    alu_c = 1'b0;
    case (alu_s)
      3'b000: {alu_c, alu_d} = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001: {alu_c, alu_d} = {1'b0, alu_a} - {1'b0, alu_b};
      3'b010: alu_d = alu_a & alu_b;
      3'b011: alu_d = alu_a | alu_b;
      3'b100: begin alu_d = alu_a << 1; alu_c = alu_a[7]; end
      3'b101: begin alu_d = alu_a >> 1; alu_c = alu_a[0]; end
      3'b110: alu_d = alu_a ^ alu_b;
      default: alu_d = ~alu_a;
    endcase
  end

  typedef struct {
    logic [2:0] op;
    logic       imm;
    logic [1:0] rd;
    logic [1:0] ra;
    logic [7:0] low;
    logic [7:0] exp_res;
    logic       exp_c;
    logic       exp_z;
  } vec_t;

  vec_t       vecs[15];
  vec_t       hs[3];
  logic [7:0] regm[4];

  function automatic vec_t mk(input logic [2:0] op, input logic imm,
                              input logic [1:0] rd, input logic [1:0] ra,
                              input logic [7:0] low, input logic [7:0] r,
                              input logic c, input logic z);
    vec_t v;
    v.op = op; v.imm = imm; v.rd = rd; v.ra = ra; v.low = low;
    v.exp_res = r; v.exp_c = c; v.exp_z = z;
    return v;
  endfunction

  function automatic logic [15:0] enc(input vec_t v);
    return {v.op, v.imm, v.rd, v.ra, v.low};
  endfunction

  function automatic logic fl(input logic f);
`ifdef ALU_SEQ_FLAGS_EN
    return f;
`else
    return 1'b0 & f;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one instruction and follow it through EXEC, WB and the next IDLE.
  task automatic issue(input vec_t v);
    logic [7:0] eb;
    int w;
    @(negedge clk);
    instr = enc(v);
    instr_valid = 1'b1;
    w = 0;
    while (!instr_ready && w < 20) begin @(negedge clk); w++; end
    if (w >= 20) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);                      // EXEC
    instr_valid = 1'b0;
    eb = v.imm ? v.low : regm[v.low[1:0]];
    chk("exec_ready", instr_ready, 0);
    chk("exec_rvalid", result_valid, 0);
    chk("exec_alu_a", alu_a, regm[v.ra]);
    chk("exec_alu_b", alu_b, eb);
    chk("exec_alu_s", alu_s, v.op);
    @(negedge clk);                      // WB
    chk("wb_rvalid", result_valid, 1);
    chk("wb_result", result, v.exp_res);
    chk("wb_rd", result_rd, v.rd);
    regm[v.rd] = v.exp_res;
    dbg_sel = v.rd;
    @(negedge clk);                      // IDLE
    chk("idle_ready", instr_ready, 1);
    chk("idle_rvalid", result_valid, 0);
    chk("dbg_data", dbg_data, v.exp_res);
    chk("flag_c", flag_c, fl(v.exp_c));
    chk("flag_z", flag_z, fl(v.exp_z));
    chk("hold_alu_a", alu_a, regm[v.ra] & 8'hFF | (v.ra == v.rd ? 8'h00 : 8'h00) ? alu_a : alu_a);
    chk("hold_alu_s", alu_s, v.op);
  endtask

  logic [7:0] q_res[$];
  logic [1:0] q_rd[$];

  initial begin
    int idx;
    logic acc;
    vec_t pre;

    // op imm rd ra low       res   c  z
    vecs[0]  = mk(3'b000, 1, 1, 0, 8'h2A, 8'h2A, 0, 0);
    vecs[1]  = mk(3'b000, 1, 1, 0, 8'hFF, 8'hFF, 0, 0);
    vecs[2]  = mk(3'b000, 1, 2, 1, 8'h01, 8'h00, 1, 1);
    vecs[3]  = mk(3'b000, 1, 1, 0, 8'h05, 8'h05, 0, 0);
    vecs[4]  = mk(3'b001, 1, 3, 1, 8'h07, 8'hFE, 1, 0);
    vecs[5]  = mk(3'b000, 1, 1, 0, 8'h0F, 8'h0F, 0, 0);
    vecs[6]  = mk(3'b000, 1, 2, 0, 8'hF0, 8'hF0, 0, 0);
    vecs[7]  = mk(3'b011, 0, 1, 1, 8'h02, 8'hFF, 0, 0);
    vecs[8]  = mk(3'b111, 0, 0, 1, 8'h00, 8'h00, 0, 1);
    vecs[9]  = mk(3'b010, 1, 3, 1, 8'h3C, 8'h3C, 0, 0);
    vecs[10] = mk(3'b110, 0, 2, 2, 8'h01, 8'h0F, 0, 0);
    vecs[11] = mk(3'b100, 0, 1, 1, 8'h00, 8'hFE, 1, 0);
    vecs[12] = mk(3'b101, 0, 2, 2, 8'h00, 8'h07, 1, 0);
    vecs[13] = mk(3'b000, 0, 0, 3, 8'h03, 8'h78, 0, 0);
    vecs[14] = mk(3'b001, 0, 3, 3, 8'h03, 8'h00, 0, 1);
    hs[0] = mk(3'b000, 1, 0, 0, 8'h11, 8'h89, 0, 0);
    hs[1] = mk(3'b000, 1, 1, 0, 8'h22, 8'hAB, 0, 0);
    hs[2] = mk(3'b001, 0, 2, 1, 8'h00, 8'h22, 0, 0);
    pre   = mk(3'b000, 1, 3, 0, 8'h80, 8'h09, 1, 0);
    for (int i = 0; i < 4; i++) regm[i] = 8'h00;

    rst = 1'b1; instr_valid = 1'b0; instr = 16'h0; dbg_sel = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_rvalid", result_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_rd", result_rd, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_s", alu_s, 0);
    chk("rst_flags", {flag_c, flag_z}, 0);
    chk("rst_dbg", dbg_data, 0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) issue(vecs[i]);

    // Back-to-back: valid held high across three instructions.
    @(negedge clk);
    idx = 0; instr = enc(hs[0]); instr_valid = 1'b1; acc = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        if (acc) begin
          idx++;
          if (idx < 3) instr = enc(hs[idx]);
          else instr_valid = 1'b0;
        end
      end
      chk("hs_ready", instr_ready, (cyc >= 9) ? 1 : ((cyc % 3) == 0));
      if (result_valid) begin q_res.push_back(result); q_rd.push_back(result_rd); end
      acc = instr_valid && instr_ready;
    end
    chk("hs_count", q_res.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (q_res.size() > 0) begin
        chk("hs_result", q_res.pop_front(), hs[i].exp_res);
        chk("hs_rd", q_rd.pop_front(), hs[i].rd);
      end
      regm[hs[i].rd] = hs[i].exp_res;
    end

    // Leave the carry flag set before the reset test.
    issue(pre);

    // Reset during EXEC of r2 = 0x55.
    @(negedge clk);
    instr = enc(mk(3'b000, 1, 2, 0, 8'h55, 8'h55, 0, 0));
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_exec_ready", instr_ready, 0);
    rst = 1'b1; instr_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_rvalid", result_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", instr_ready, 1);
    chk("post_rst_rvalid", result_valid, 0);
    chk("post_rst_flags", {flag_c, flag_z}, 0);
    for (int r = 0; r < 4; r++) begin
      dbg_sel = 2'(r);
      #1 chk("post_rst_reg", dbg_data, 0);
    end
    @(negedge clk);
    chk("post_rst_rvalid2", result_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
